reverb_fir_mac_stream: RTL and testbench
========================================

# reverb_fir_mac_stream

Time-multiplexed single-multiplier FIR filter for one reverb channel. It accepts 16-bit samples on an Avalon-ST sink, convolves them with a TAPS-entry coefficient set loaded over an Avalon-MM write slave, and emits 32-bit sign-extended results on an Avalon-ST source. The source drives the sink of the channel's stream-to-memory-mapped output FIFO, so it must tolerate that FIFO's early, level-based `ready` deassertion.

## Interface
- `TAPS`, 32: number of taps; must be a power of two, 4..256.
- `AW`, $clog2(TAPS): coefficient address width.
- `clock` in 1: single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `sink_data` in 32: sample in `[15:0]`, signed; `[31:16]` ignored.
- `sink_valid` in 1: sample present.
- `sink_ready` out 1: block can accept a sample.
- `source_data` out 32: filtered sample, signed 16 bits sign-extended to 32.
- `source_valid` out 1: result present.
- `source_ready` in 1: downstream accepts.
- `coef_address` in AW: tap index k.
- `coef_write` in 1: coefficient write strobe.
- `coef_writedata` in 32: coefficient in `[15:0]`, signed Q1.15.
- `coef_waitrequest` out 1: write stalled.

## Operation
- States: INIT, IDLE, MAC, DRAIN1, DRAIN2, OUT.
- **INIT:** entered on reset. Writes 0 to delay-line entries 0..TAPS-1, one per cycle, then goes to IDLE. `wr_ptr` resets to 0.
- **IDLE:** `sink_ready` is 1.
  - On `sink_valid & sink_ready`, store `sink_data[15:0]` at `x[wr_ptr]`, clear the accumulator and go to MAC.
- **MAC:** lasts TAPS cycles. In cycle k (k = 0..TAPS-1), issue coefficient address k and delay-line address `(wr_ptr - k) mod TAPS`.
- **Datapath:** 2-stage pipeline.
  - Stage 1 registers the operands.
  - Stage 2 registers the 32-bit signed product.
  - The accumulator (ACC_W = 32 + AW bits, signed) adds the product on the following edge.
- **DRAIN1, DRAIN2:** one cycle each, to flush the pipeline.
- **Leaving DRAIN2:**
  - `source_data` ← sign-extended `sat16(acc >>> 15)`.
  - `sat16` clamps to [-32768, 32767]; the shift is arithmetic (floor).
  - Enter OUT.
- **OUT:** `source_valid` is 1 and `source_data` is held stable.
  - On `source_ready`, increment `wr_ptr` (mod TAPS) and go to IDLE.
- **Coefficient writes:**
  - `coef_waitrequest` = (state is MAC, DRAIN1 or DRAIN2).
  - A write completes in the first cycle where `coef_write` is high and `coef_waitrequest` is low.
  - Coefficients are therefore constant for the whole of each convolution.
- **Coefficient retention:** coefficients are not cleared by reset and are undefined at power-up.
- **Handshakes:** transfers occur only in cycles where valid and ready are both high. `sink_valid` may be high outside IDLE; the sample is not consumed until IDLE.

## Timing
- **Reset values:**
  - `sink_ready` = 0
  - `source_valid` = 0
  - `source_data` = 0
  - `coef_waitrequest` = 0
- **Reset mid-operation:** reset is asynchronous. Any in-flight result is discarded and INIT re-runs.
- **After reset release:** `sink_ready` first goes to 1 exactly TAPS cycles later (INIT length).
- **Latency:** sink handshake in cycle c0 gives `source_valid` high first in cycle c0 + TAPS + 3 (35 for TAPS = 32).
- **Throughput:** at best one sample per TAPS + 4 cycles (1 IDLE + TAPS MAC + 2 drain + 1 OUT with `source_ready` = 1).
- **Back-to-back:** a source handshake in cycle t makes IDLE, with `sink_ready` = 1, occur in cycle t + 1.
- **Wrap-around:** `wr_ptr` and the tap index wrap mod TAPS with no bubble.
- **Simultaneous events:**
  - A coefficient write in IDLE coincident with a sink handshake completes, and the new value is used in that convolution.
  - A coefficient write issued during INIT completes.

## Structure
- **Package `reverb_fir_pkg`:**
  - state enum `fir_state_t`;
  - `SAMPLE_W` = 16 and `COEF_W` = 16;
  - `FRAC_SHIFT` = 15;
  - function `sat16(acc)`.
- **Sub-module `reverb_fir_mac_datapath`:**
  - operand registers, multiplier, accumulator, saturation and output register;
  - controls: `clear`, `en`, `load_out`.
- **Top level:** FSM, address generation and the two inferred RAMs (delay line and coefficients, 1-cycle read).

## Test plan
- **Reset/INIT:**
  - Stimulus: release reset with `sink_valid` = 1.
  - Required: `sink_ready` = 0 for 32 cycles, then 1; all outputs 0 during reset.
- **Impulse response:**
  - Stimulus: coef[k] = 0x0100·(k+1); send 0x7FFF followed by 32 zeros; `source_ready` = 1.
  - Required: outputs are 255, 511, …, 8191, then 0; first `source_valid` 35 cycles after the first sink handshake.
- **Saturation:**
  - Stimulus: all coefficients 0x7FFF; 32 samples of 0x7FFF.
  - Required: 32nd output = 0x00007FFF.
  - Stimulus: repeat with samples of 0x8000.
  - Required: 32nd output = 0xFFFF8000.
- **Backpressure:**
  - Stimulus: hold `source_ready` = 0 for 10 cycles in OUT.
  - Required: `source_valid` and `source_data` stable; `sink_ready` = 0; the next sample is not accepted until the cycle after the handshake.
- **Coefficient write during MAC:**
  - Stimulus: write coef[0] = 0x4000 mid-MAC.
  - Required: `coef_waitrequest` = 1 until OUT; current output uses the old value; the next output (input 1000, all other taps 0) is 500.
- **Reset mid-MAC:**
  - Stimulus: assert `reset_n` = 0 in MAC cycle 10.
  - Required: `source_valid` stays 0 and the delay line re-clears. With the original coefficients still loaded, the next impulse reproduces the full impulse response (255, 511, …, 8191) from the start.

Source files
------------

// File: rtl/reverb_fir_pkg.sv
// Shared types, widths and saturation helper for the reverb FIR MAC stream.
package reverb_fir_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_MAC,
        ST_DRAIN1,
        ST_DRAIN2,
        ST_OUT
    } fir_state_t;

    localparam int SAMPLE_W   = 16;
    localparam int COEF_W     = 16;
    localparam int FRAC_SHIFT = 15;

    localparam logic signed [63:0] SAT_MAX = 64'sd32767;
    localparam logic signed [63:0] SAT_MIN = -64'sd32768;

    // Clamp an already-shifted accumulator value into the signed 16-bit range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [63:0] acc);
        if (acc > SAT_MAX) begin
            return 16'sh7FFF;
        end else if (acc < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return acc[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/reverb_fir_mac_stream_if.sv
// Sample sink, result source and coefficient write port of one reverb FIR channel.
interface reverb_fir_mac_stream_if #(
    parameter int AW = 5
);
    logic [31:0]   sink_data;
    logic          sink_valid;
    logic          sink_ready;
    logic [31:0]   source_data;
    logic          source_valid;
    logic          source_ready;
    logic [AW-1:0] coef_address;
    logic          coef_write;
    logic [31:0]   coef_writedata;
    logic          coef_waitrequest;

    // Filter side.
    modport slave (
        input  sink_data, sink_valid, source_ready,
        input  coef_address, coef_write, coef_writedata,
        output sink_ready, source_data, source_valid, coef_waitrequest
    );

    // Stream producer / consumer / register master side.
    modport master (
        output sink_data, sink_valid, source_ready,
        output coef_address, coef_write, coef_writedata,
        input  sink_ready, source_data, source_valid, coef_waitrequest
    );
endinterface

// File: rtl/reverb_fir_mac_datapath.sv
// Multiply-accumulate pipeline: product register, accumulator, saturating output register.
// The operands arrive already registered (the RAM read registers form the first stage).
module reverb_fir_mac_datapath
    import reverb_fir_pkg::*;
#(
    parameter int ACC_W = 37
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       en,
    input  logic                       load_out,
    input  logic signed [SAMPLE_W-1:0] x_i,
    input  logic signed [COEF_W-1:0]   c_i,
    output logic [31:0]                result_o
);
    logic                    op_valid_q;
    logic                    prod_valid_q;
    logic signed [31:0]      prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [63:0]      acc_ext;
    logic signed [15:0]      sat_val;
    logic [31:0]             out_q;

    // Next accumulator value; the output load uses it so the final product is included.
    always_comb begin
        acc_d   = acc_q + (prod_valid_q ? {{(ACC_W-32){prod_q[31]}}, prod_q} : '0);
        acc_ext = {{(64-ACC_W){acc_d[ACC_W-1]}}, acc_d};
        sat_val = sat16(acc_ext >>> FRAC_SHIFT);
    end

    // Pipeline valid tracking, product, accumulator and held result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_valid_q   <= 1'b0;
            prod_valid_q <= 1'b0;
            prod_q       <= '0;
            acc_q        <= '0;
            out_q        <= '0;
        end else begin
            op_valid_q   <= en;
            prod_valid_q <= op_valid_q;
            prod_q       <= x_i * c_i;
            acc_q        <= clear ? '0 : acc_d;
            if (load_out) begin
                out_q <= {{16{sat_val[15]}}, sat_val};
            end
        end
    end

    assign result_o = out_q;

endmodule

// File: rtl/reverb_fir_mac_stream.sv
// Time-multiplexed single-multiplier FIR for one reverb channel: control FSM,
// address generation, delay-line and coefficient RAMs.
module reverb_fir_mac_stream
    import reverb_fir_pkg::*;
#(
    parameter int TAPS = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    reverb_fir_mac_stream_if.slave bus
);
    localparam int             AW       = $clog2(TAPS);
    localparam logic [AW-1:0]  LAST_IDX = AW'(TAPS - 1);

    fir_state_t                 state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic                       x_we;
    logic [AW-1:0]              x_waddr;
    logic signed [SAMPLE_W-1:0] x_wdata;
    logic [AW-1:0]              x_raddr;
    logic                       c_we;
    logic signed [SAMPLE_W-1:0] x_mem [TAPS];
    logic signed [COEF_W-1:0]   c_mem [TAPS];
    logic signed [SAMPLE_W-1:0] x_rd_q;
    logic signed [COEF_W-1:0]   c_rd_q;
    logic                       dp_clear, dp_en, dp_load;

    // Control state, shared INIT/MAC counter and delay-line write pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wr_ptr_d       = wr_ptr_q;
        x_we           = 1'b0;
        x_waddr        = cnt_q;
        x_wdata        = '0;
        dp_clear       = 1'b0;
        dp_en          = 1'b0;
        dp_load        = 1'b0;
        bus.sink_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                x_we  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                bus.sink_ready = 1'b1;
                if (bus.sink_valid) begin
                    x_we     = 1'b1;
                    x_waddr  = wr_ptr_q;
                    x_wdata  = bus.sink_data[SAMPLE_W-1:0];
                    dp_clear = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                dp_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN1;
                end
            end
            ST_DRAIN1: begin
                state_d = ST_DRAIN2;
            end
            ST_DRAIN2: begin
                dp_load = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.source_ready) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Coefficients are frozen while a convolution is in flight.
    assign bus.coef_waitrequest = (state_q == ST_MAC) || (state_q == ST_DRAIN1) ||
                                  (state_q == ST_DRAIN2);
    assign bus.source_valid     = (state_q == ST_OUT);
    assign c_we                 = bus.coef_write && !bus.coef_waitrequest;
    assign x_raddr              = wr_ptr_q - cnt_q;

    // Delay line: newest sample at wr_ptr, tap k reads wr_ptr - k.
    always_ff @(posedge clock) begin
        if (x_we) begin
            x_mem[x_waddr] <= x_wdata;
        end
        x_rd_q <= x_mem[x_raddr];
    end

    // Coefficient store; not cleared by reset.
    always_ff @(posedge clock) begin
        if (c_we) begin
            c_mem[bus.coef_address] <= bus.coef_writedata[COEF_W-1:0];
        end
        c_rd_q <= c_mem[cnt_q];
    end

    reverb_fir_mac_datapath #(
        .ACC_W (32 + AW)
    ) u_datapath (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (dp_clear),
        .en       (dp_en),
        .load_out (dp_load),
        .x_i      (x_rd_q),
        .c_i      (c_rd_q),
        .result_o (bus.source_data)
    );

endmodule

// File: tb/tb_reverb_fir_mac_stream.sv
// Self-checking bench for reverb_fir_mac_stream against a direct-form FIR model.
module tb_reverb_fir_mac_stream;
    localparam int TAPS = 32;
    localparam int AW   = 5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    reverb_fir_mac_stream_if #(.AW(AW)) bus ();

    reverb_fir_mac_stream #(.TAPS(TAPS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: coefficient values and last TAPS samples (index 0 = newest).
    int coef_m [TAPS];
    int hist_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) @cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist_q.delete();
        repeat (TAPS) hist_q.push_back(0);
    endtask

    task automatic model_push(input logic [15:0] s);
        hist_q.push_front(int'($signed(s)));
        void'(hist_q.pop_back());
    endtask

    function automatic int model_out();
        longint acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(hist_q[k]) * longint'(coef_m[k]);
        acc = acc >>> 15;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    // Tasks below start and end just after a falling edge.
    task automatic write_coef(input int addr, input logic [15:0] val);
        int st = 0;
        bus.coef_address   = addr[AW-1:0];
        bus.coef_writedata = {16'($urandom), val};
        bus.coef_write     = 1'b1;
        while (bus.coef_waitrequest && st < 200) begin
            @(negedge clock);
            st++;
        end
        if (st >= 200) check_eq("coef_wait_timeout", st, 0);
        @(negedge clock);
        bus.coef_write = 1'b0;
        coef_m[addr] = int'($signed(val));
    endtask

    task automatic send_sample(input logic [15:0] s, input bit cw, output int hs);
        int n = 0;
        int a;
        logic [15:0] v;
        bus.sink_data  = {16'($urandom), s};
        bus.sink_valid = 1'b1;
        while (!bus.sink_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check_eq("sink_timeout", n, 0);
        hs = cyc;
        if (cw) begin
            a = $urandom_range(0, TAPS - 1);
            v = 16'($urandom);
            bus.coef_address   = a[AW-1:0];
            bus.coef_writedata = {16'($urandom), v};
            bus.coef_write     = 1'b1;
            coef_m[a] = int'($signed(v));
        end
        model_push(s);
        @(negedge clock);
        bus.sink_valid = 1'b0;
        bus.coef_write = 1'b0;
    endtask

    task automatic wait_valid(input int hs);
        int n = 0;
        while (!bus.source_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check_eq("source_timeout", n, 0);
        check_eq("latency", cyc - hs, TAPS + 3);
    endtask

    task automatic recv_check(input string tag, input int hold, input int hs, output logic [31:0] got);
        bus.source_ready = 1'b0;
        wait_valid(hs);
        got = bus.source_data;
        check_eq(tag, got, model_out());
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_eq("hold_data", bus.source_data, got);
        end
        bus.source_ready = 1'b1;
        @(negedge clock);
        bus.source_ready = 1'b0;
        check_eq("b2b_sink_ready", bus.sink_ready, 1'b1);
    endtask

    task automatic run_impulse(input string tag);
        int hs;
        logic [31:0] got;
        for (int n = 0; n <= TAPS; n++) begin
            send_sample((n == 0) ? 16'h7FFF : 16'h0000, 1'b0, hs);
            recv_check(tag, 0, hs, got);
            if (n == 0)    check_eq({tag, "_first"}, got, 32'd255);
            if (n == 31)   check_eq({tag, "_last"}, got, 32'd8191);
            if (n == TAPS) check_eq({tag, "_after"}, got, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs2, n;
        bit seen;
        logic [31:0] got;
        logic [15:0] s2;

        bus.sink_data      = 32'h1234_5678;
        bus.sink_valid     = 1'b1;
        bus.source_ready   = 1'b0;
        bus.coef_write     = 1'b0;
        bus.coef_address   = '0;
        bus.coef_writedata = '0;

        // Reset state with a sample already offered.
        repeat (3) @(negedge clock);
        check_eq("rst_sink_ready", bus.sink_ready, 1'b0);
        check_eq("rst_source_valid", bus.source_valid, 1'b0);
        check_eq("rst_source_data", bus.source_data, 32'd0);
        check_eq("rst_waitrequest", bus.coef_waitrequest, 1'b0);

        // INIT: impulse coefficients written while the delay line is cleared.
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < TAPS; i++) begin
            bus.coef_address   = i[AW-1:0];
            bus.coef_writedata = 32'(256 * (i + 1));
            bus.coef_write     = 1'b1;
            coef_m[i] = 256 * (i + 1);
            @(negedge clock);
            check_eq("init_sink_ready", bus.sink_ready, (i == TAPS - 1) ? 1'b1 : 1'b0);
        end
        bus.coef_write = 1'b0;
        bus.sink_valid = 1'b0;

        run_impulse("impulse");

        // Reset in MAC cycle 10, then the impulse must reproduce cleanly.
        send_sample(16'h7FFF, 1'b0, hs);
        repeat (10) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_source_valid", bus.source_valid, 1'b0);
        check_eq("mid_rst_source_data", bus.source_data, 32'd0);
        check_eq("mid_rst_waitrequest", bus.coef_waitrequest, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        n = 0;
        seen = 1'b0;
        while (!bus.sink_ready && n < 200) begin
            @(negedge clock);
            n++;
            if (bus.source_valid) seen = 1'b1;
        end
        check_eq("mid_rst_init_len", n, TAPS);
        check_eq("mid_rst_no_valid", seen, 1'b0);
        run_impulse("impulse_after_rst");

        // Saturation, both polarities.
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'h7FFF);
        for (int i = 0; i < TAPS; i++) begin
            send_sample(16'h7FFF, 1'b0, hs);
            recv_check("sat_pos", 0, hs, got);
        end
        check_eq("sat_pos_32nd", got, 32'h0000_7FFF);
        for (int i = 0; i < TAPS; i++) begin
            send_sample(16'h8000, 1'b0, hs);
            recv_check("sat_neg", 0, hs, got);
        end
        check_eq("sat_neg_32nd", got, 32'hFFFF_8000);

        // Backpressure: result held, next sample refused until after the source handshake.
        send_sample(16'($urandom), 1'b0, hs);
        bus.source_ready = 1'b0;
        wait_valid(hs);
        got = bus.source_data;
        check_eq("bp_data", got, model_out());
        s2 = 16'($urandom);
        bus.sink_data  = {16'hA5A5, s2};
        bus.sink_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_eq("bp_valid", bus.source_valid, 1'b1);
            check_eq("bp_hold", bus.source_data, got);
            check_eq("bp_sink_ready", bus.sink_ready, 1'b0);
        end
        bus.source_ready = 1'b1;
        @(negedge clock);
        bus.source_ready = 1'b0;
        check_eq("bp_idle_sink_ready", bus.sink_ready, 1'b1);
        hs2 = cyc;
        model_push(s2);
        @(negedge clock);
        bus.sink_valid = 1'b0;
        bus.source_ready = 1'b0;
        wait_valid(hs2);
        check_eq("bp_next", bus.source_data, model_out());
        bus.source_ready = 1'b1;
        @(negedge clock);
        bus.source_ready = 1'b0;

        // Coefficient write issued mid-MAC stalls until OUT.
        for (int i = 0; i < TAPS; i++) write_coef(i, (i == 0) ? 16'h2000 : 16'h0000);
        send_sample(16'd1000, 1'b0, hs);
        repeat (5) @(negedge clock);
        bus.coef_address   = '0;
        bus.coef_writedata = 32'h0000_4000;
        bus.coef_write     = 1'b1;
        n = 0;
        while (bus.coef_waitrequest && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("cw_stall_cycles", n, 29);
        check_eq("cw_done_in_out", bus.source_valid, 1'b1);
        check_eq("cw_old_coef_out", bus.source_data, model_out());
        check_eq("cw_old_coef_val", bus.source_data, 32'd250);
        bus.source_ready = 1'b1;
        @(negedge clock);
        bus.coef_write   = 1'b0;
        bus.source_ready = 1'b0;
        coef_m[0] = 32'h4000;
        send_sample(16'd1000, 1'b0, hs);
        recv_check("cw_new_coef_out", 0, hs, got);
        check_eq("cw_new_coef_val", got, 32'd500);

        // Randomised traffic with coefficient writes coincident with handshakes.
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'($urandom));
        for (int i = 0; i < 24; i++) begin
            send_sample(16'($urandom), 1'($urandom), hs);
            recv_check("random", $urandom_range(0, 2), hs, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
